// File: rtl/mux2_stream_arbiter_pkg.sv
// Shared definitions for the two-requester stream arbiter: FSM state encoding
// and the default datapath width.
package mux2_stream_arbiter_pkg;

  localparam int unsigned BIT_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux2_stream_arbiter_mux2to1.sv
// Two-input word multiplexer: Y follows A when S is low, B when S is high.
module Mux2to1
  import mux2_stream_arbiter_pkg::*;
#(
  parameter int unsigned bit_size = BIT_SIZE_DEF
) (
  input  logic [bit_size-1:0] A,
  input  logic [bit_size-1:0] B,
  input  logic                S,
  output logic [bit_size-1:0] Y
);

  always_comb begin
    Y = S ? B : A;
  end

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin burst arbiter sharing one mux path between two valid/ready
// requesters, with a one-entry registered output stage.
module mux2_stream_arbiter
  import mux2_stream_arbiter_pkg::*;
#(
  parameter int unsigned bit_size  = BIT_SIZE_DEF,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [bit_size-1:0] req0_data,
  input  logic                req0_last,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [bit_size-1:0] req1_data,
  input  logic                req1_last,
  output logic                req1_ready,
  output logic                out_valid,
  output logic [bit_size-1:0] out_data,
  input  logic                out_ready,
  output logic                sel,
  output logic                busy
);

  arb_state_t          state_q, state_d;
  logic                prio_q, prio_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                sel_q, sel_d;
  logic                out_valid_q, out_valid_d;
  logic [bit_size-1:0] out_data_q, out_data_d;

  logic [bit_size-1:0] mux_y;
  logic                load_en;
  logic                xfer;
  logic                beat_last;

  Mux2to1 #(.bit_size(bit_size)) u_mux (
    .A (req0_data),
    .B (req1_data),
    .S (sel_q),
    .Y (mux_y)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    beat_cnt_d  = beat_cnt_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    busy        = 1'b0;
    xfer        = 1'b0;
    beat_last   = 1'b0;
    load_en     = !out_valid_q || out_ready;

    case (state_q)
      ST_IDLE: begin
        if ((prio_q ? req1_valid : req0_valid)) begin
          state_d = prio_q ? ST_GRANT1 : ST_GRANT0;
          sel_d   = prio_q;
        end else if ((prio_q ? req0_valid : req1_valid)) begin
          state_d = prio_q ? ST_GRANT0 : ST_GRANT1;
          sel_d   = !prio_q;
        end
      end
      ST_GRANT0: begin
        busy       = 1'b1;
        req0_ready = load_en;
        xfer       = req0_valid && load_en;
        beat_last  = req0_last;
      end
      ST_GRANT1: begin
        busy       = 1'b1;
        req1_ready = load_en;
        xfer       = req1_valid && load_en;
        beat_last  = req1_last;
      end
      default: state_d = ST_IDLE;
    endcase

    // A load always wins over a drain, so a simultaneous drain+load keeps out_valid high.
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
      if (beat_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
        state_d    = ST_IDLE;
        prio_d     = (state_q == ST_GRANT0);
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      beat_cnt_q  <= '0;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      beat_cnt_q  <= beat_cnt_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;

endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit datapath, the existing Mux2to1 select path, between two valid/ready requesters.
- Grants one requester at a time for a burst, drives the mux select, and registers the selected beat into a one-entry output stage with valid/ready back-pressure.
- Sits between two producer units (e.g. ALU result and load data) and a single downstream consumer/write port.

Parameters:
bit_size, 16, data width of requesters, mux and output register
MAX_BURST, 4, maximum beats per grant before a forced release (>=1)
CNT_W, 2, width of beat counter; must hold MAX_BURST-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
req0_valid  input  1  requester 0 has a beat
req0_data  input  bit_size  requester 0 beat
req0_last  input  1  final beat of requester 0 burst
req0_ready  output  1  beat of requester 0 accepted this cycle when high with valid
req1_valid  input  1  requester 1 has a beat
req1_data  input  bit_size  requester 1 beat
req1_last  input  1  final beat of requester 1 burst
req1_ready  output  1  beat of requester 1 accepted when high with valid
out_valid  output  1  output register holds a beat
out_data  output  bit_size  registered beat
out_ready  input  1  consumer accepts out beat
sel  output  1  current mux select (0=req0, 1=req1), registered
busy  output  1  high in GRANT0/GRANT1

Behaviour:
- One clock (clk), reset synchronous active-high (rst); all state updates on rising clk.
- Reset state: state=IDLE, prio=0, beat_cnt=0, sel=0, out_valid=0, out_data=0. Combinational outputs during reset: req0_ready=0, req1_ready=0, busy=0.
- rst asserted mid-burst: returns to reset state next edge; the in-flight output beat is dropped.
- load_en = !out_valid || out_ready (output stage empty or draining this cycle).
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE: both readys 0.
  - If req[prio]_valid, go to GRANT[prio].
  - Else if the other requester is valid, go to its GRANT.
  - Else stay.
  - sel loads the granted index on the same edge; sel holds its value while in IDLE.
  - Arbitration costs one cycle; the first beat transfers at the earliest in the cycle after leaving IDLE.
- GRANTx:
  - reqx_ready = load_en; the other ready = 0.
  - Transfer when reqx_valid && reqx_ready: out_data <= reqx_data (via mux with S=sel), out_valid <= 1, beat_cnt++.
  - Release condition: a transfer with reqx_last=1, or beat_cnt==MAX_BURST-1.
  - On release: state <= IDLE, prio <= ~x, beat_cnt <= 0.
  - reqx_valid low mid-burst: grant held; no timeout. Requesters must finish bursts.
- Output stage:
  - If out_valid && out_ready and no new load: out_valid <= 0.
  - Simultaneous drain and load: out_valid stays 1 and out_data takes the new beat, giving full throughput of 1 beat/cycle.
  - out_data is stable while out_valid && !out_ready.
- Latency: requester beat to out_valid is 1 cycle.
- Back-to-back grants: one IDLE bubble between bursts (accepted cost).
- Both valid in IDLE: prio winner takes the grant. After its release the other requester is granted next (strict alternation under contention).
- A single requester with MAX_BURST=1: alternates IDLE/GRANT, 1 beat per 2 cycles.
- beat_cnt never exceeds MAX_BURST-1; no wrap.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_GRANT0=2'd1, ST_GRANT1=2'd2), bit_size default.
- Sub-module: instantiate existing Mux2to1 (bit_size passthrough) for the data select, with S driven by sel. The FSM, counter and output register live in this block.

Test Plan:
- Reset: rst=1 for 2 cycles with both valids high -> out_valid=0, sel=0, both readys 0, busy=0; first grant goes to req0 (prio=0).
- Single burst: req0 sends 0x1111,0x2222,0x3333 (last on 3rd), out_ready=1 -> out_data 0x1111/0x2222/0x3333 on consecutive cycles, 1-cycle latency; then IDLE, prio=1.
- Contention: both valid continuously, no last, MAX_BURST=4 -> 4 beats from req0, 1 idle cycle, 4 beats from req1, sel toggles 0->1; repeated.
- Back-pressure: during a req1 burst, out_ready=0 for 3 cycles with out_data=0xBEEF -> out_data holds 0xBEEF, req1_ready=0; resumes with no lost or duplicated beat.
- Mid-burst valid gap: req0 valid low for 2 cycles after its 1st beat while req1 valid -> grant stays GRANT0, req1_ready=0 until req0 sends last.
- Reset mid-burst: rst pulsed while in GRANT1 with out_valid=1 -> next cycle state IDLE, out_valid=0, sel=0, prio=0.
